// File: rtl/hidden_weight_loader.sv
// Run-time loadable hidden-layer weight store.
// Byte stream in over valid/ready, row-wise parallel read out.
module hidden_weight_loader #(
   parameter int ROWS  = 2,
   parameter int COLS  = 10,
   parameter int WIDTH = 8,
   localparam int TW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             busy,
   output logic             done,
   input  logic [TW-1:0]    t,
   output logic [WIDTH-1:0] res0,
   output logic [WIDTH-1:0] res1,
   output logic [WIDTH-1:0] res2,
   output logic [WIDTH-1:0] res3,
   output logic [WIDTH-1:0] res4,
   output logic [WIDTH-1:0] res5,
   output logic [WIDTH-1:0] res6,
   output logic [WIDTH-1:0] res7,
   output logic [WIDTH-1:0] res8,
   output logic [WIDTH-1:0] res9
);

   localparam int N  = ROWS * COLS;
   localparam int AW = (N > 1) ? $clog2(N) : 1;
   localparam logic [AW-1:0] LAST = AW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_DONE
   } state_e;

   state_e                               state_q;
   logic [AW-1:0]                        addr_q;
   logic                                 in_ready_q;
   logic                                 busy_q;
   logic                                 done_q;
   logic [ROWS-1:0][COLS-1:0][WIDTH-1:0] mem_q;
   logic [COLS-1:0][WIDTH-1:0]           rd;
   logic                                 accept;

   // A restart pulse takes priority over a byte offered in the same cycle.
   assign accept = in_ready_q && in_valid && !start;

   // Load sequencer: address counter plus registered handshake/status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q    <= S_LOAD;
                  addr_q     <= '0;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b1;
               end
            end
            S_LOAD: begin
               if (start) begin
                  addr_q <= '0;
               end else if (accept) begin
                  if (addr_q == LAST) begin
                     state_q    <= S_DONE;
                     in_ready_q <= 1'b0;
                     busy_q     <= 1'b0;
                     done_q     <= 1'b1;
                  end else begin
                     addr_q <= addr_q + 1'b1;
                  end
               end
            end
            S_DONE: begin
               if (start) begin
                  state_q    <= S_LOAD;
                  addr_q     <= '0;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b1;
                  done_q     <= 1'b0;
               end
            end
            default: begin
               state_q    <= S_IDLE;
               addr_q     <= '0;
               in_ready_q <= 1'b0;
               busy_q     <= 1'b0;
               done_q     <= 1'b0;
            end
         endcase
      end
   end

   // Each cell captures the accepted byte when the linear address hits it.
   for (genvar r = 0; r < ROWS; r++) begin : g_row
      for (genvar c = 0; c < COLS; c++) begin : g_col
         localparam logic [AW-1:0] A = AW'(r * COLS + c);
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               mem_q[r][c] <= '0;
            end else if (accept && (addr_q == A)) begin
               mem_q[r][c] <= in_data;
            end
         end
      end
   end

   // Combinational row read; out-of-range rows read as zero.
   always_comb begin
      rd = '0;
      if (int'(t) < ROWS) begin
         rd = mem_q[t];
      end
   end

   assign in_ready = in_ready_q;
   assign busy     = busy_q;
   assign done     = done_q;

   assign res0 = rd[0];
   assign res1 = rd[1];
   assign res2 = rd[2];
   assign res3 = rd[3];
   assign res4 = rd[4];
   assign res5 = rd[5];
   assign res6 = rd[6];
   assign res7 = rd[7];
   assign res8 = rd[8];
   assign res9 = rd[9];

endmodule

// File: tb/tb_hidden_weight_loader.sv
// Scoreboard bench for hidden_weight_loader.
// Driver pushes model predictions; monitor pops and compares after each edge.
module tb_hidden_weight_loader;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = '0;
   logic       t = 1'b0;
   logic       in_ready;
   logic       busy;
   logic       done;
   logic [7:0] res0, res1, res2, res3, res4;
   logic [7:0] res5, res6, res7, res8, res9;
   logic [9:0][7:0] dres;

   hidden_weight_loader dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .busy(busy), .done(done),
      .t(t),
      .res0(res0), .res1(res1), .res2(res2), .res3(res3), .res4(res4),
      .res5(res5), .res6(res6), .res7(res7), .res8(res8), .res9(res9)
   );

   assign dres = {res9, res8, res7, res6, res5, res4, res3, res2, res1, res0};

   always #5 clk = ~clk;

   typedef struct packed {
      logic            tt;
      logic            rdy;
      logic            bsy;
      logic            dn;
      logic [9:0][7:0] res;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model: a byte array, a write pointer and two phase flags.
   logic [7:0] ref_mem [20];
   bit         m_load;
   bit         m_done;
   int         m_ptr;

   function automatic void model_reset();
      for (int i = 0; i < 20; i++) ref_mem[i] = 8'h00;
      m_load = 0;
      m_done = 0;
      m_ptr  = 0;
   endfunction

   function automatic logic [79:0] ref_row(input int r);
      logic [79:0] v;
      for (int k = 0; k < 10; k++) v[k*8 +: 8] = ref_mem[r*10 + k];
      return v;
   endfunction

   task automatic check(input string name, input logic [79:0] act,
                        input logic [79:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock of stimulus; the prediction for after the next edge is queued.
   task automatic cyc(input bit s, input bit v, input logic [7:0] d,
                      input logic tt);
      exp_t e;
      @(negedge clk);
      start    = s;
      in_valid = v;
      in_data  = d;
      t        = tt;
      if (s) begin
         m_load = 1;
         m_done = 0;
         m_ptr  = 0;
      end else if (m_load && v) begin
         ref_mem[m_ptr] = d;
         m_ptr++;
         if (m_ptr == 20) begin
            m_load = 0;
            m_done = 1;
         end
      end
      e.tt  = tt;
      e.rdy = m_load;
      e.bsy = m_load;
      e.dn  = m_done;
      e.res = ref_row(int'(tt));
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 8'h00, 1'(i % 2));
   endtask

   task automatic check_reset_now(input string tag);
      check({tag, "_ready"}, 80'(in_ready), 80'(0));
      check({tag, "_busy"}, 80'(busy), 80'(0));
      check({tag, "_done"}, 80'(done), 80'(0));
      t = 1'b0;
      #1;
      check({tag, "_row0"}, dres, 80'(0));
      t = 1'b1;
      #1;
      check({tag, "_row1"}, dres, 80'(0));
   endtask

   // Monitor: compare DUT against the oldest queued prediction.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("in_ready", 80'(in_ready), 80'(e.rdy));
            check("busy", 80'(busy), 80'(e.bsy));
            check("done", 80'(done), 80'(e.dn));
            check(e.tt ? "row1" : "row0", dres, e.res);
         end
      end
   end

   initial begin
      model_reset();
      #12;
      check_reset_now("rst");
      @(negedge clk);
      rst_n = 1'b1;

      // Idle writes are ignored.
      for (int i = 0; i < 5; i++) cyc(0, 1, 8'hAA, 1'(i % 2));
      idle(2);

      // Full back-to-back load.
      cyc(1, 0, 8'h00, 1'b0);
      for (int i = 0; i < 20; i++) cyc(0, 1, 8'(i), 1'(i / 10));
      idle(4);

      // Stalled load, valid toggling.
      cyc(1, 0, 8'h00, 1'b0);
      for (int i = 0; i < 40; i++)
         cyc(0, (i % 2) == 0, (i % 2) == 0 ? 8'(i / 2) : 8'hEE,
             1'($urandom_range(0, 1)));
      idle(4);

      // Restart mid-load; the byte under start is dropped.
      cyc(1, 0, 8'h00, 1'b0);
      for (int i = 0; i < 7; i++) cyc(0, 1, 8'h55, 1'b0);
      cyc(1, 1, 8'hEE, 1'b0);
      for (int i = 0; i < 20; i++) cyc(0, 1, 8'h33, 1'(i % 2));
      idle(4);

      // Reload after completion.
      cyc(1, 0, 8'h00, 1'b0);
      for (int i = 0; i < 20; i++) cyc(0, 1, 8'(i), 1'b0);
      cyc(1, 0, 8'h00, 1'b0);
      for (int i = 0; i < 3; i++) cyc(0, 1, 8'(8'hF0 + i), 1'b0);
      idle(4);

      // Random traffic.
      for (int i = 0; i < 400; i++)
         cyc($urandom_range(0, 29) == 0, 1'($urandom_range(0, 1)),
             8'($urandom), 1'($urandom_range(0, 1)));
      idle(2);

      // Asynchronous reset after 12 bytes.
      cyc(1, 0, 8'h00, 1'b0);
      for (int i = 0; i < 12; i++) cyc(0, 1, 8'(8'hC0 + i), 1'(i % 2));
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_now("arst");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      idle(3);

      repeat (2) @(posedge clk);
      #2;
      check("queue_drain", 80'(exp_q.size()), 80'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
